// File: rtl/rx.sv
// rx: receive-side gPTP message block.
// Validates incoming PTP frames and unpacks them into a 5-slot x 4-field
// register file. Each accepted frame is announced to the gPTP core with a
// message-type notification, and the core reads the stored fields back
// through a registered read port.
module rx #(
  parameter logic [7:0] DOMAIN  = 8'd0,
  parameter logic [3:0] VERSION = 4'd2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gptp_rx_vaild,
  output logic         gptp_rx_ready,
  input  logic [351:0] gptp_rx_data,
  input  logic [79:0]  gptp_rx_ts,
  output logic         gptp_rx_msg_vaild,
  input  logic         gptp_rx_msg_ready,
  output logic [3:0]   gptp_rx_msg_type,
  input  logic [7:0]   gptp_rd_addr,
  output logic [79:0]  gptp_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    WRITE  = 2'd2,
    NOTIFY = 2'd3
  } state_t;

  state_t       state_r;

  // Fields latched from the accepted frame.
  logic [3:0]   type_r;
  logic [3:0]   ver_r;
  logic [7:0]   dom_r;
  logic [79:0]  spi_r;
  logic [15:0]  seq_r;
  logic [79:0]  body_r;
  logic [79:0]  ts_r;

  logic [2:0]   slot_r;
  logic [1:0]   field_r;
  logic [15:0]  acc_cnt_r;
  logic [15:0]  drop_cnt_r;

  // 20 words: word index = {slot, field}.
  logic [79:0]  regs_r [0:19];

  logic         supported_s;
  logic [2:0]   chk_slot_s;
  logic         pass_s;
  logic [4:0]   wr_idx_s;
  logic [79:0]  wr_data_s;
  logic [79:0]  rd_data_s;
  logic [2:0]   rd_slot_s;

  // Header bytes this block does not interpret; folded into one signal so
  // the intent of ignoring them is explicit.
  logic         unused_hdr_s;
  assign unused_hdr_s = ^{gptp_rx_data[351:348], gptp_rx_data[343:340],
                          gptp_rx_data[335:320], gptp_rx_data[311:192],
                          gptp_rx_data[95:80]};

  // Map messageType to its storage slot and flag unsupported types.
  always_comb begin
    supported_s = 1'b0;
    chk_slot_s  = 3'd0;
    case (type_r)
      4'h0: begin supported_s = 1'b1; chk_slot_s = 3'd0; end
      4'h8: begin supported_s = 1'b1; chk_slot_s = 3'd1; end
      4'h2: begin supported_s = 1'b1; chk_slot_s = 3'd2; end
      4'h3: begin supported_s = 1'b1; chk_slot_s = 3'd3; end
      4'hA: begin supported_s = 1'b1; chk_slot_s = 3'd4; end
      default: begin supported_s = 1'b0; chk_slot_s = 3'd0; end
    endcase
    pass_s = supported_s && (ver_r == VERSION) && (dom_r == DOMAIN);
  end

  // Select the field word written in the current WRITE cycle.
  always_comb begin
    wr_idx_s  = {slot_r, field_r};
    wr_data_s = 80'd0;
    case (field_r)
      2'd0:    wr_data_s = ts_r;
      2'd1:    wr_data_s = body_r;
      2'd2:    wr_data_s = {64'd0, seq_r};
      2'd3:    wr_data_s = spi_r;
      default: wr_data_s = 80'd0;
    endcase
  end

  // Control FSM: frame acceptance, validation, write sequencing, notify
  // handshake and the two saturating frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      gptp_rx_ready     <= 1'b0;
      gptp_rx_msg_vaild <= 1'b0;
      gptp_rx_msg_type  <= 4'd0;
      type_r            <= 4'd0;
      ver_r             <= 4'd0;
      dom_r             <= 8'd0;
      spi_r             <= 80'd0;
      seq_r             <= 16'd0;
      body_r            <= 80'd0;
      ts_r              <= 80'd0;
      slot_r            <= 3'd0;
      field_r           <= 2'd0;
      acc_cnt_r         <= 16'd0;
      drop_cnt_r        <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gptp_rx_ready && gptp_rx_vaild) begin
            type_r        <= gptp_rx_data[347:344];
            ver_r         <= gptp_rx_data[339:336];
            dom_r         <= gptp_rx_data[319:312];
            spi_r         <= gptp_rx_data[191:112];
            seq_r         <= gptp_rx_data[111:96];
            body_r        <= gptp_rx_data[79:0];
            ts_r          <= gptp_rx_ts;
            gptp_rx_ready <= 1'b0;
            state_r       <= CHECK;
          end else begin
            gptp_rx_ready <= 1'b1;
          end
        end
        CHECK: begin
          if (pass_s) begin
            slot_r  <= chk_slot_s;
            field_r <= 2'd0;
            state_r <= WRITE;
          end else begin
            if (drop_cnt_r != 16'hFFFF) begin
              drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            gptp_rx_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        WRITE: begin
          if (field_r == 2'd3) begin
            if (acc_cnt_r != 16'hFFFF) begin
              acc_cnt_r <= acc_cnt_r + 16'd1;
            end
            gptp_rx_msg_vaild <= 1'b1;
            gptp_rx_msg_type  <= type_r;
            state_r           <= NOTIFY;
          end else begin
            field_r <= field_r + 2'd1;
          end
        end
        NOTIFY: begin
          if (gptp_rx_msg_ready) begin
            gptp_rx_msg_vaild <= 1'b0;
            gptp_rx_ready     <= 1'b1;
            state_r           <= IDLE;
          end
        end
        default: begin
          gptp_rx_ready     <= 1'b0;
          gptp_rx_msg_vaild <= 1'b0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

  // Register file: cleared on reset, one field word written per WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 20; i++) begin
        regs_r[i] <= 80'd0;
      end
    end else if (state_r == WRITE) begin
      regs_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Read address decode: slot words, the two counters, zero elsewhere.
  always_comb begin
    rd_slot_s = gptp_rd_addr[4:2];
    rd_data_s = 80'd0;
    if ((gptp_rd_addr[7:5] == 3'b000) && (rd_slot_s <= 3'd4)) begin
      rd_data_s = regs_r[gptp_rd_addr[4:0]];
    end else if (gptp_rd_addr == 8'h20) begin
      rd_data_s = {64'd0, acc_cnt_r};
    end else if (gptp_rd_addr == 8'h21) begin
      rd_data_s = {64'd0, drop_cnt_r};
    end else begin
      rd_data_s = 80'd0;
    end
  end

  // Registered read port; sees pre-write / pre-increment values.
  always_ff @(posedge clk) begin
    if (reset) begin
      gptp_rd_data <= 80'd0;
    end else begin
      gptp_rd_data <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_rx.sv
// Directed, self-checking bench for rx. Expected read data and expected
// notification types are queued when stimulus is driven and popped when the
// DUT produces the matching output.
module tb_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic         gptp_rx_vaild;
  logic         gptp_rx_ready;
  logic [351:0] gptp_rx_data;
  logic [79:0]  gptp_rx_ts;
  logic         gptp_rx_msg_vaild;
  logic         gptp_rx_msg_ready;
  logic [3:0]   gptp_rx_msg_type;
  logic [7:0]   gptp_rd_addr;
  logic [79:0]  gptp_rd_data;

  always #5 clk = ~clk;

  rx #(.DOMAIN(8'd0), .VERSION(4'd2)) dut (
    .clk               (clk),
    .reset             (reset),
    .gptp_rx_vaild     (gptp_rx_vaild),
    .gptp_rx_ready     (gptp_rx_ready),
    .gptp_rx_data      (gptp_rx_data),
    .gptp_rx_ts        (gptp_rx_ts),
    .gptp_rx_msg_vaild (gptp_rx_msg_vaild),
    .gptp_rx_msg_ready (gptp_rx_msg_ready),
    .gptp_rx_msg_type  (gptp_rx_msg_type),
    .gptp_rd_addr      (gptp_rd_addr),
    .gptp_rd_data      (gptp_rd_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [79:0] exp_q [$];
  string       tag_q [$];
  logic [3:0]  type_q [$];

  localparam logic [79:0] TS1   = {5{16'h5555}};
  localparam logic [79:0] BODY1 = {5{16'hAAAA}};
  localparam logic [79:0] SPI1  = 80'h0011_2233_4455_6677_0001;
  localparam logic [79:0] TS2   = 80'h0000_0000_0102_1111_2222;
  localparam logic [79:0] BODY2 = 80'h0000_0000_0203_3333_4444;
  localparam logic [79:0] SPI2  = 80'h8899_AABB_CCDD_EEFF_0002;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [351:0] frame(input logic [3:0] t, input logic [3:0] v,
                                         input logic [7:0] d, input logic [79:0] spi,
                                         input logic [15:0] seq, input logic [79:0] body);
    logic [351:0] f;
    f = {11{32'hDEADBEEF}};
    f[347:344] = t;
    f[339:336] = v;
    f[319:312] = d;
    f[191:112] = spi;
    f[111:96]  = seq;
    f[79:0]    = body;
    return f;
  endfunction

  // Registered read: expected value queued with the address, compared one
  // cycle later when the data appears.
  task automatic rd(input logic [7:0] a, input logic [79:0] exp, input string tag);
    gptp_rd_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    chk(tag_q.pop_front(), gptp_rd_data, exp_q.pop_front());
  endtask

  // Present a frame until accepted; returns at the CHECK cycle (T+1).
  task automatic send(input logic [351:0] f, input logic [79:0] ts,
                      input logic notify, input logic [3:0] exp_type, input string tag);
    gptp_rx_data  = f;
    gptp_rx_ts    = ts;
    gptp_rx_vaild = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (gptp_rx_ready) break;
      step();
    end
    chk({tag, "_accept"}, {79'd0, gptp_rx_ready}, 80'd1);
    if (notify) type_q.push_back(exp_type);
    step();
    gptp_rx_vaild = 1'b0;
  endtask

  // Bounded wait for a notification; compares against the queued type.
  task automatic wait_msg(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (gptp_rx_msg_vaild) break;
      step();
    end
    chk({tag, "_vaild"}, {79'd0, gptp_rx_msg_vaild}, 80'd1);
    if (type_q.size() > 0) begin
      chk({tag, "_type"}, {76'd0, gptp_rx_msg_type}, {76'd0, type_q.pop_front()});
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    step();
    chk({tag, "_rst_vaild"}, {79'd0, gptp_rx_msg_vaild}, 80'd0);
    chk({tag, "_rst_ready"}, {79'd0, gptp_rx_ready}, 80'd0);
    reset = 1'b0;
    step();
    chk({tag, "_ready_after"}, {79'd0, gptp_rx_ready}, 80'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_t;
    logic       seen;
    reset             = 1'b1;
    gptp_rx_vaild     = 1'b0;
    gptp_rx_data      = 352'd0;
    gptp_rx_ts        = 80'd0;
    gptp_rx_msg_ready = 1'b1;
    gptp_rd_addr      = 8'd0;

    // Reset state
    step(); step(); step();
    chk("rst_ready", {79'd0, gptp_rx_ready}, 80'd0);
    chk("rst_msg_vaild", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    chk("rst_msg_type", {76'd0, gptp_rx_msg_type}, 80'd0);
    chk("rst_rd_data", gptp_rd_data, 80'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", {79'd0, gptp_rx_ready}, 80'd1);
    rd(8'h00, 80'd0, "rd_init_00");
    rd(8'h20, 80'd0, "rd_init_acc");
    rd(8'h21, 80'd0, "rd_init_drop");

    // Sync frame: exact notification latency and stored fields
    send(frame(4'h0, 4'h2, 8'h00, SPI1, 16'h1234, BODY1), TS1, 1'b1, 4'h0, "sync");
    chk("sync_ready_T1", {79'd0, gptp_rx_ready}, 80'd0);
    step(); step(); step(); step();
    chk("sync_vaild_T5", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    step();
    chk("sync_vaild_T6", {79'd0, gptp_rx_msg_vaild}, 80'd1);
    chk("sync_type_T6", {76'd0, gptp_rx_msg_type}, {76'd0, type_q.pop_front()});
    step();
    chk("sync_ready_T7", {79'd0, gptp_rx_ready}, 80'd1);
    chk("sync_vaild_T7", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    rd(8'h00, TS1, "sync_ingress_ts");
    rd(8'h01, BODY1, "sync_body_ts");
    rd(8'h02, 80'h1234, "sync_seq");
    rd(8'h03, SPI1, "sync_spi");
    rd(8'h20, 80'd1, "sync_acc_cnt");
    rd(8'h21, 80'd0, "sync_drop_cnt");
    rd(8'h14, 80'd0, "unmapped_14");
    rd(8'h22, 80'd0, "unmapped_22");

    // Wrong domain: dropped, ready back at T+2
    send(frame(4'h0, 4'h2, 8'h01, SPI2, 16'h0BAD, BODY2), TS2, 1'b0, 4'h0, "dom");
    chk("dom_ready_T1", {79'd0, gptp_rx_ready}, 80'd0);
    step();
    chk("dom_ready_T2", {79'd0, gptp_rx_ready}, 80'd1);
    chk("dom_no_vaild", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    rd(8'h21, 80'd1, "dom_drop_cnt");
    rd(8'h00, TS1, "dom_slot_kept_ts");
    rd(8'h02, 80'h1234, "dom_slot_kept_seq");

    // Announce type and version 1 frames: dropped
    send(frame(4'hB, 4'h2, 8'h00, SPI2, 16'h0B0B, BODY2), TS2, 1'b0, 4'h0, "announce");
    step();
    chk("announce_ready_T2", {79'd0, gptp_rx_ready}, 80'd1);
    send(frame(4'h0, 4'h1, 8'h00, SPI2, 16'h0101, BODY2), TS2, 1'b0, 4'h0, "ver1");
    step();
    chk("ver1_ready_T2", {79'd0, gptp_rx_ready}, 80'd1);
    chk("ver1_no_vaild", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    rd(8'h21, 80'd3, "drop_cnt_3");
    rd(8'h20, 80'd1, "acc_cnt_still_1");
    rd(8'h02, 80'h1234, "sync_seq_kept");

    // Pdelay_Resp with notification held off for 10 cycles, second frame waiting
    gptp_rx_msg_ready = 1'b0;
    send(frame(4'h3, 4'h2, 8'h00, SPI2, 16'h0303, BODY2), TS2, 1'b1, 4'h3, "presp");
    gptp_rx_data  = frame(4'h0, 4'h2, 8'h00, SPI1, 16'h4444, BODY1);
    gptp_rx_ts    = TS1;
    gptp_rx_vaild = 1'b1;
    type_q.push_back(4'h0);
    step(); step(); step(); step(); step();
    exp_t = type_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk("presp_hold_vaild", {79'd0, gptp_rx_msg_vaild}, 80'd1);
      chk("presp_hold_type", {76'd0, gptp_rx_msg_type}, {76'd0, exp_t});
      chk("presp_hold_ready", {79'd0, gptp_rx_ready}, 80'd0);
      step();
    end
    chk("presp_pre_hs_ready", {79'd0, gptp_rx_ready}, 80'd0);
    gptp_rx_msg_ready = 1'b1;
    step();
    chk("presp_post_hs_ready", {79'd0, gptp_rx_ready}, 80'd1);
    chk("presp_post_hs_vaild", {79'd0, gptp_rx_msg_vaild}, 80'd0);
    step();
    chk("second_accepted", {79'd0, gptp_rx_ready}, 80'd0);
    gptp_rx_vaild = 1'b0;
    wait_msg("second");
    step();
    rd(8'h0C, TS2, "presp_ingress_ts");
    rd(8'h0D, BODY2, "presp_body_ts");
    rd(8'h0E, 80'h0303, "presp_seq");
    rd(8'h0F, SPI2, "presp_spi");
    rd(8'h02, 80'h4444, "second_sync_seq");
    rd(8'h20, 80'd3, "acc_cnt_3");

    // Back-to-back Follow_Up from a clean state
    do_reset("fu");
    send(frame(4'h8, 4'h2, 8'h00, SPI1, 16'h0001, BODY1), TS1, 1'b1, 4'h8, "fu1");
    wait_msg("fu1");
    step();
    send(frame(4'h8, 4'h2, 8'h00, SPI2, 16'h0002, BODY2), TS2, 1'b1, 4'h8, "fu2");
    wait_msg("fu2");
    step();
    rd(8'h06, 80'h0002, "fu_seq");
    rd(8'h05, BODY2, "fu_body");
    rd(8'h20, 80'd2, "fu_acc_cnt");
    rd(8'h02, 80'd0, "fu_sync_cleared");

    // Reset in the middle of the WRITE state
    send(frame(4'h0, 4'h2, 8'h00, SPI1, 16'h9999, BODY1), TS1, 1'b0, 4'h0, "midrst");
    step(); step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("midrst_ready", {79'd0, gptp_rx_ready}, 80'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gptp_rx_msg_vaild) seen = 1'b1;
      step();
    end
    chk("midrst_no_vaild", {79'd0, seen}, 80'd0);
    rd(8'h00, 80'd0, "midrst_00");
    rd(8'h01, 80'd0, "midrst_01");
    rd(8'h02, 80'd0, "midrst_02");
    rd(8'h05, 80'd0, "midrst_05");
    rd(8'h06, 80'd0, "midrst_06");
    rd(8'h20, 80'd0, "midrst_acc");
    rd(8'h21, 80'd0, "midrst_drop");

    // Drop counter saturation, starting just below the limit
    force dut.drop_cnt_r = 16'hFFFE;
    step();
    release dut.drop_cnt_r;
    rd(8'h21, 80'hFFFE, "sat_start");
    send(frame(4'h0, 4'h2, 8'h05, SPI1, 16'h0001, BODY1), TS1, 1'b0, 4'h0, "sat1");
    step();
    rd(8'h21, 80'hFFFF, "sat_reach");
    send(frame(4'h0, 4'h2, 8'h05, SPI1, 16'h0002, BODY1), TS1, 1'b0, 4'h0, "sat2");
    step();
    rd(8'h21, 80'hFFFF, "sat_hold");
    rd(8'h20, 80'd0, "sat_acc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx.md
# rx

Receive-side gPTP block, the counterpart of the `tx` path. It accepts 352-bit PTP event/general messages plus an 80-bit ingress timestamp from the MAC receive side. It validates each frame and unpacks the fields into an internal 80-bit-word register file, then signals the gPTP core with a message-type notification. The core reads the stored fields through an addressed read port.

## Interface
- `DOMAIN`, default 8'd0: accepted `domainNumber`.
- `VERSION`, default 4'd2: accepted `versionPTP` (low nibble of byte 1).
- `clk`  in  1: single clock, all logic rising-edge.
- `reset`  in  1: synchronous, active-high.
- `gptp_rx_vaild`  in  1: MAC frame valid.
- `gptp_rx_ready`  out  1: block can accept a frame.
- `gptp_rx_data`  in  352: 34-byte PTP header + 10-byte body timestamp. Byte k is at `[351-8k -: 8]`.
- `gptp_rx_ts`  in  80: ingress timestamp of the frame (48-bit seconds, 32-bit ns).
- `gptp_rx_msg_vaild`  out  1: new message stored.
- `gptp_rx_msg_ready`  in  1: core acknowledges the notification.
- `gptp_rx_msg_type`  out  4: messageType of the stored message.
- `gptp_rd_addr`  in  8: register-file read address.
- `gptp_rd_data`  out  80: read data.

## Operation
- Field extraction:
  - messageType = `[347:344]`
  - version = `[339:336]`
  - domain = `[319:312]`
  - sourcePortIdentity = `[191:112]`
  - sequenceId = `[111:96]`
  - body timestamp = `[79:0]`
- Supported types and slots: Sync 0x0 → slot 0, Follow_Up 0x8 → 1, Pdelay_Req 0x2 → 2, Pdelay_Resp 0x3 → 3, Pdelay_Resp_Follow_Up 0xA → 4.
- Address map: addr = {3'b000, slot[2:0], field[1:0]}.
  - field 0: ingress ts
  - field 1: body ts
  - field 2: {64'd0, sequenceId}
  - field 3: sourcePortIdentity
- Counters:
  - 8'h20: accepted-frame counter, 16-bit, zero-extended to 80.
  - 8'h21: dropped-frame counter, 16-bit, zero-extended to 80.
  - Both saturate at 16'hFFFF.
- All other addresses read 80'd0.
- FSM states: IDLE, CHECK, WRITE, NOTIFY.
  - IDLE: `gptp_rx_ready`=1. On `gptp_rx_vaild`&&`gptp_rx_ready`, latch data and ts, go to CHECK.
  - CHECK: pass requires version==`VERSION`, domain==`DOMAIN`, and a supported type.
    - Pass → WRITE with field index 0.
    - Fail → drop counter +1, back to IDLE.
  - WRITE: writes one field per cycle, fields 0..3 into the slot, 4 cycles total. After field 3: accepted counter +1, go to NOTIFY.
  - NOTIFY: `gptp_rx_msg_vaild`=1 and `gptp_rx_msg_type` is held stable until `gptp_rx_msg_ready`. On the handshake → IDLE.
- A newer message of the same type overwrites the slot. No queueing, no history.

## Timing
- Reset (synchronous) clears:
  - FSM to IDLE
  - all 20 slot words and both counters to 0
  - `gptp_rx_msg_vaild`=0, `gptp_rx_msg_type`=0, `gptp_rd_data`=0
  - `gptp_rx_ready` goes to 1 in the cycle after reset deasserts.
- Reset mid-frame (any state) aborts the frame. Partial slot writes are cleared, nothing is notified, no counter increments.
- Accept at cycle T:
  - CHECK at T+1.
  - Writes at T+2..T+5.
  - `gptp_rx_msg_vaild` high from T+6.
  - With `gptp_rx_msg_ready` held high, the handshake is at T+6 and the next accept is at T+7 at the earliest.
- Dropped frame: back in IDLE at T+2, so the next accept is at T+2.
- `gptp_rx_ready` is low in CHECK/WRITE/NOTIFY. A MAC-side `gptp_rx_vaild` must hold its data until accepted.
- Read port is registered with 1-cycle latency: `gptp_rd_data` at T+1 reflects `gptp_rd_addr` at T.
- Read and write to the same word in the same cycle return the old value (read-before-write).
- Counter increment and read in the same cycle return the pre-increment value.

## Test plan
- Sync, seqId 0x1234, body ts 0xAA.., ingress ts 0x55.., accepted at T. Required response:
  - `gptp_rx_msg_vaild` rises at T+6 with type 0x0.
  - Reads of 8'h00/01/02 give 0x55.., 0xAA.., 0x1234.
  - 8'h20 reads 1.
- Frame with domain=1 (`DOMAIN`=0) → no notification, 8'h21 reads 1, slots unchanged, `gptp_rx_ready` back at T+2.
- Frame with type 0xB (Announce) → dropped as above. Version 1 frame → dropped.
- Pdelay_Resp accepted while `gptp_rx_msg_ready` is held low for 10 cycles → valid and type stay stable, `gptp_rx_ready` stays 0. Second frame is accepted only the cycle after the handshake.
- Back-to-back Follow_Up, seqId 1 then 2 → slot 1 field 2 reads 2, accepted count reads 2.
- Assert reset during the WRITE state → all reads return 0, no `gptp_rx_msg_vaild`. Counter saturation: force 65536 drops → 8'h21 reads 0xFFFF.
